// File: rtl/alu_seq_nibble_ctrl_pkg.sv
// Shared types and constants for the nibble-serial 74181 ALU controller.
// State encodings and the commonly used 74181 function selects.
package alu_seq_nibble_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] S_ADD  = 4'b1001;  // M=0: A plus B
  localparam logic [3:0] S_SUB  = 4'b0110;  // M=0: A minus B minus 1 (plus carry)
  localparam logic [3:0] S_NOTA = 4'b0000;  // M=1: not A

endpackage

// File: rtl/alu_seq_nibble_ctrl_alu.sv
// 4-bit 74181-style ALU slice, active-high data, active-low Cn/Cn4.
// Ripple-only use: the lookahead X/Y group outputs are not provided.
module alu_seq_nibble_ctrl_alu (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] S,
  input  logic       M,
  input  logic       Cn,
  output logic [3:0] F,
  output logic       Cn4,
  output logic       AeqB
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c0, c1, c2, c3, c4;

  always_comb begin
    g  = (A & ~B & {4{S[2]}}) | (A & B & {4{S[3]}});
    p  = A | (B & {4{S[0]}}) | (~B & {4{S[1]}});
    // Internal carries are active-high; the pins use 74181 (active-low) polarity.
    c0 = ~Cn;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & c1);
    c3 = g[2] | (p[2] & c2);
    c4 = g[3] | (p[3] & c3);
    // M=1 forces every carry term to 1, which yields the complemented logic functions.
    F    = p ^ g ^ ({c3, c2, c1, c0} | {4{M}});
    Cn4  = ~c4;
    AeqB = &F;
  end

endmodule

// File: rtl/alu_seq_nibble_ctrl.sv
// Multi-cycle WIDTH-bit ALU: one 74181 slice used one nibble per clock, LSB first.
// Define ALU_SEQ_OVF_EN to add the signed-add overflow output `ovf`.
module alu_seq_nibble_ctrl
  import alu_seq_nibble_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             Cn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cn_out,
  output logic             AeqB
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = $clog2(NIB);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [3:0]        s_q;
  logic              m_q;
  logic              carry_q;
  logic              aeq_acc_q;
  logic [CntW-1:0]   nib_cnt_q;

  logic [3:0]        a_nib, b_nib, f_slice;
  logic              cn4_slice, aeqb_slice;
  logic              accept, last_nib;

  assign a_nib = a_q[{nib_cnt_q, 2'b00} +: 4];
  assign b_nib = b_q[{nib_cnt_q, 2'b00} +: 4];

  alu_seq_nibble_ctrl_alu u_alu (
    .A    (a_nib),
    .B    (b_nib),
    .S    (s_q),
    .M    (m_q),
    .Cn   (carry_q),
    .F    (f_slice),
    .Cn4  (cn4_slice),
    .AeqB (aeqb_slice)
  );

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    accept    = in_valid && in_ready;
    last_nib  = (nib_cnt_q == CntW'(NIB - 1));
    state_d   = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_nib)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      carry_q   <= 1'b0;
      aeq_acc_q <= 1'b0;
      nib_cnt_q <= '0;
      F         <= '0;
      Cn_out    <= 1'b0;
      AeqB      <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (state_q == ST_IDLE && accept) begin
        a_q       <= A;
        b_q       <= B;
        s_q       <= S;
        m_q       <= M;
        carry_q   <= Cn;
        aeq_acc_q <= 1'b1;
        nib_cnt_q <= '0;
      end
      if (state_q == ST_RUN) begin
        F[{nib_cnt_q, 2'b00} +: 4] <= f_slice;
        carry_q   <= cn4_slice;
        aeq_acc_q <= aeq_acc_q & aeqb_slice;
        nib_cnt_q <= nib_cnt_q + 1'b1;
        if (last_nib) begin
          Cn_out <= cn4_slice;
          AeqB   <= aeq_acc_q & aeqb_slice;
`ifdef ALU_SEQ_OVF_EN
          // f_slice[3] is the result sign bit on the last nibble.
          ovf    <= !m_q && (s_q == S_ADD) && (a_q[WIDTH-1] == b_q[WIDTH-1])
                    && (f_slice[3] != a_q[WIDTH-1]);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_nibble_ctrl.sv
// Directed self-checking bench for alu_seq_nibble_ctrl at WIDTH=16.
// Honours ALU_SEQ_OVF_EN when defined.
module tb_alu_seq_nibble_ctrl;
  import alu_seq_nibble_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic [3:0]  S = '0;
  logic        M = 1'b0;
  logic        Cn = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] F;
  logic        Cn_out;
  logic        AeqB;
`ifdef ALU_SEQ_OVF_EN
  logic        ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq_nibble_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .M         (M),
    .Cn        (Cn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .F         (F),
    .Cn_out    (Cn_out),
    .AeqB      (AeqB)
`ifdef ALU_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Issues one request and waits (bounded) for out_valid; optionally keeps a
  // conflicting request asserted while the operation runs.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input logic m, input logic cn, input bit noise,
                        output logic rdy_acc, output int lat, output logic rdy_seen);
    @(negedge clk);
    A = a; B = b; S = s; M = m; Cn = cn; in_valid = 1'b1;
    rdy_acc = in_ready;
    @(posedge clk);
    @(negedge clk);
    if (noise) begin
      A = ~a; B = ~b; S = 4'b0011; M = ~m; Cn = ~cn;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      rdy_seen = rdy_seen | in_ready;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (F !== 16'h0000) begin errors++; $display("FAIL reset_F got=%h exp=0000", F); end
    checks++; if (Cn_out !== 1'b0 || AeqB !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", Cn_out, AeqB); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
`ifdef ALU_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    logic r_acc, r_seen; int lat;
    run_op(16'h1234, 16'h0101, S_ADD, 1'b0, 1'b1, 1'b0, r_acc, lat, r_seen);
    checks++; if (r_acc !== 1'b1) begin errors++; $display("FAIL add_accept_ready got=%b exp=1", r_acc); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", lat); end
    checks++; if (F !== 16'h1335) begin errors++; $display("FAIL add_F got=%h exp=1335", F); end
    checks++; if (Cn_out !== 1'b1) begin errors++; $display("FAIL add_Cn_out got=%b exp=1", Cn_out); end
    checks++; if (AeqB !== 1'b0) begin errors++; $display("FAIL add_AeqB got=%b exp=0", AeqB); end
`ifdef ALU_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_ovf got=%b exp=0", ovf); end
`endif
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL add_release got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready);
    end
  endtask

  task automatic test_carry_ripple();
    logic r_acc, r_seen; int lat;
    run_op(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 1'b0, r_acc, lat, r_seen);
    checks++; if (F !== 16'h0000) begin errors++; $display("FAIL ripple_F got=%h exp=0000", F); end
    checks++; if (Cn_out !== 1'b0) begin errors++; $display("FAIL ripple_Cn_out got=%b exp=0", Cn_out); end
`ifdef ALU_SEQ_OVF_EN
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ripple_ovf got=%b exp=0", ovf); end
`endif
    handshake();
  endtask

  task automatic test_compare();
    logic r_acc, r_seen; int lat;
    run_op(16'h0005, 16'h0005, S_SUB, 1'b0, 1'b1, 1'b0, r_acc, lat, r_seen);
    checks++; if (F !== 16'hFFFF) begin errors++; $display("FAIL cmp_eq_F got=%h exp=ffff", F); end
    checks++; if (AeqB !== 1'b1) begin errors++; $display("FAIL cmp_eq_AeqB got=%b exp=1", AeqB); end
    checks++; if (Cn_out !== 1'b1) begin errors++; $display("FAIL cmp_eq_Cn_out got=%b exp=1", Cn_out); end
    handshake();
    run_op(16'h0006, 16'h0005, S_SUB, 1'b0, 1'b1, 1'b0, r_acc, lat, r_seen);
    checks++; if (r_acc !== 1'b1) begin errors++; $display("FAIL b2b_accept_ready got=%b exp=1", r_acc); end
    checks++; if (F !== 16'h0000) begin errors++; $display("FAIL cmp_ne_F got=%h exp=0000", F); end
    checks++; if (AeqB !== 1'b0) begin errors++; $display("FAIL cmp_ne_AeqB got=%b exp=0", AeqB); end
    checks++; if (Cn_out !== 1'b0) begin errors++; $display("FAIL cmp_ne_Cn_out got=%b exp=0", Cn_out); end
    handshake();
  endtask

  task automatic test_backpressure();
    logic r_acc, r_seen; int lat;
    run_op(16'h00F0, 16'h1234, S_NOTA, 1'b1, 1'b1, 1'b0, r_acc, lat, r_seen);
    checks++; if (lat !== 4) begin errors++; $display("FAIL logic_latency got=%0d exp=4", lat); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || F !== 16'hFF0F) begin
        errors++; $display("FAIL bp_hold%0d got=valid%b F%h exp=valid1 Fff0f", i, out_valid, F);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
    end
    checks++; if (Cn_out !== 1'b1) begin errors++; $display("FAIL logic_Cn_out got=%b exp=1", Cn_out); end
    handshake();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got=valid%b ready%b exp=valid0 ready1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic r_acc, r_seen; int lat;
    @(negedge clk);
    A = 16'h1234; B = 16'h0101; S = S_ADD; M = 1'b0; Cn = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || AeqB !== 1'b0) begin
      errors++; $display("FAIL midrst_flags got=valid%b AeqB%b exp=00", out_valid, AeqB);
    end
    checks++; if (F !== 16'h0000) begin errors++; $display("FAIL midrst_F got=%h exp=0000", F); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_idle got=ready%b valid%b exp=ready1 valid0", in_ready, out_valid);
    end
    run_op(16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b0, 1'b0, r_acc, lat, r_seen);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
    checks++; if (F !== 16'h1011) begin errors++; $display("FAIL midrst_fresh_F got=%h exp=1011", F); end
    handshake();
  endtask

  task automatic test_overflow_ignore();
    logic r_acc, r_seen; int lat;
    run_op(16'h7FFF, 16'h0001, S_ADD, 1'b0, 1'b1, 1'b1, r_acc, lat, r_seen);
    checks++; if (r_seen !== 1'b0) begin errors++; $display("FAIL run_in_ready got=%b exp=0", r_seen); end
    checks++; if (F !== 16'h8000) begin errors++; $display("FAIL ovf_F got=%h exp=8000", F); end
    checks++; if (Cn_out !== 1'b1) begin errors++; $display("FAIL ovf_Cn_out got=%b exp=1", Cn_out); end
`ifdef ALU_SEQ_OVF_EN
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
`endif
    handshake();
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ripple();
    test_compare();
    test_backpressure();
    test_reset_mid_run();
    test_overflow_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
